// File: rtl/led_pkg.sv
// Shared constants and FSM encoding for the LED stripe serializer and transmitter.
package led_pkg;

    localparam int unsigned BITS_PER_LED = 24;
    localparam int unsigned BIT_CNT_W    = 5;

    // GRB word layout: G occupies the top byte and is sent first.
    localparam int unsigned G_MSB = 23;
    localparam int unsigned B_LSB = 0;

    localparam int unsigned DEFAULT_N_LEDS       = 64;
    localparam int unsigned DEFAULT_ADDR_W       = 6;
    localparam int unsigned DEFAULT_LATCH_CYCLES = 5000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } frame_state_e;

    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(BITS_PER_LED - 1);
    endfunction

endpackage

// File: rtl/led_pixel_shifter.sv
// Holds the current and prefetched GRB words and presents the current bit MSB-first.
module led_pixel_shifter
    import led_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    shift_en,
    input  logic                    last_led,
    input  logic                    next_cap,
    input  logic [BITS_PER_LED-1:0] pix_data,
    output logic                    bit_out,
    output logic                    last_bit
);

    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [BITS_PER_LED-1:0] next_q, next_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        next_d    = next_cap ? pix_data : next_q;

        if (load) begin
            shift_d   = pix_data;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            if (!is_last_bit(bit_cnt_q)) begin
                shift_d   = {shift_q[G_MSB-1:B_LSB], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end else if (!last_led) begin
                shift_d   = next_q;
                bit_cnt_d = '0;
            end else begin
                // Clearing the word drives the line low once the frame is out.
                shift_d   = '0;
                bit_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            next_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            next_q    <= next_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_out  = shift_q[G_MSB];
    assign last_bit = is_last_bit(bit_cnt_q);

endmodule

// File: rtl/led_frame_serializer.sv
// Frame sequencer: fetches pixels, feeds the bit shifter and times the end-of-frame latch.
module led_frame_serializer
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS       = DEFAULT_N_LEDS,
    parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
    parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic                    pix_rd_en,
    output logic [ADDR_W-1:0]       pix_addr,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    new_bit_rqst,
    output logic                    bit_to_transmit,
    output logic                    all_bits_shifted,
    input  logic                    new_frame_rqst
);

    localparam int unsigned LATCH_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_LEDS - 1);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

    frame_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    led_idx_q, led_idx_d;
    logic [LATCH_W-1:0]   latch_cnt_q, latch_cnt_d;
    logic                 pend_q, pend_d;
    logic                 pf_vld_q, pf_vld_d;
    logic                 pix_rd_en_q, pix_rd_en_d;
    logic [ADDR_W-1:0]    pix_addr_q, pix_addr_d;
    logic                 abs_q, abs_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic shift_en;
    logic load;
    logic last_led;
    logic last_bit;

    assign load     = (state_q == ST_LOAD);
    assign shift_en = (state_q == ST_SHIFT) && new_bit_rqst;
    assign last_led = (led_idx_q == LAST_IDX);

    led_pixel_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .last_led (last_led),
        .next_cap (pf_vld_q),
        .pix_data (pix_data),
        .bit_out  (bit_to_transmit),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d     = state_q;
        led_idx_d   = led_idx_q;
        latch_cnt_d = latch_cnt_q;
        pend_d      = pend_q;
        pix_rd_en_d = 1'b0;
        pix_addr_d  = pix_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d     = ST_FETCH;
                    pix_rd_en_d = 1'b1;
                    pix_addr_d  = '0;
                end
            end
            ST_FETCH: begin
                state_d   = ST_LOAD;
                led_idx_d = '0;
                if (N_LEDS > 1) begin
                    pix_rd_en_d = 1'b1;
                    pix_addr_d  = ADDR_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (new_bit_rqst && last_bit) begin
                    if (last_led) begin
                        state_d     = ST_LATCH;
                        latch_cnt_d = '0;
                    end else begin
                        led_idx_d = led_idx_q + ADDR_W'(1);
                        // Keep exactly one pixel ahead of the one being shifted.
                        if (32'(led_idx_q) + 32'd2 < N_LEDS) begin
                            pix_rd_en_d = 1'b1;
                            pix_addr_d  = led_idx_q + ADDR_W'(2);
                        end
                    end
                end
            end
            ST_LATCH: begin
                pend_d = pend_q | frame_start;
                if (latch_cnt_q == LATCH_LAST) begin
                    latch_cnt_d = '0;
                    pend_d      = 1'b0;
                    if (pend_q || frame_start) begin
                        state_d     = ST_FETCH;
                        pix_rd_en_d = 1'b1;
                        pix_addr_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (new_frame_rqst) begin
                    latch_cnt_d = latch_cnt_q + LATCH_W'(1);
                end else begin
                    latch_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Data returning for any strobe other than the FETCH read belongs in next_reg.
        pf_vld_d = pix_rd_en_q && (state_q != ST_FETCH);
        abs_d    = (state_d != ST_SHIFT);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_LATCH) && (latch_cnt_d == LATCH_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            led_idx_q   <= '0;
            latch_cnt_q <= '0;
            pend_q      <= 1'b0;
            pf_vld_q    <= 1'b0;
            pix_rd_en_q <= 1'b0;
            pix_addr_q  <= '0;
            abs_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_idx_q   <= led_idx_d;
            latch_cnt_q <= latch_cnt_d;
            pend_q      <= pend_d;
            pf_vld_q    <= pf_vld_d;
            pix_rd_en_q <= pix_rd_en_d;
            pix_addr_q  <= pix_addr_d;
            abs_q       <= abs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_rd_en        = pix_rd_en_q;
    assign pix_addr         = pix_addr_q;
    assign all_bits_shifted = abs_q;
    assign frame_busy       = busy_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_led_frame_serializer.sv
// Scoreboard bench for led_frame_serializer: 3-LED frame, short latch interval.
module tb_led_frame_serializer;

    localparam int unsigned N_LEDS       = 3;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned LATCH_CYCLES = 20;

    logic              clk;
    logic              rst;
    logic              frame_start;
    logic              frame_busy;
    logic              frame_done;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic              new_bit_rqst;
    logic              bit_to_transmit;
    logic              all_bits_shifted;
    logic              new_frame_rqst;

    logic [23:0] mem [4];
    logic        exp_bits [$];
    int          exp_addr [$];
    int          n_vec;
    int          n_err;

    led_frame_serializer #(
        .N_LEDS       (N_LEDS),
        .ADDR_W       (ADDR_W),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .frame_busy       (frame_busy),
        .frame_done       (frame_done),
        .pix_rd_en        (pix_rd_en),
        .pix_addr         (pix_addr),
        .pix_data         (pix_data),
        .new_bit_rqst     (new_bit_rqst),
        .bit_to_transmit  (bit_to_transmit),
        .all_bits_shifted (all_bits_shifted),
        .new_frame_rqst   (new_frame_rqst)
    );

    always #5 clk = ~clk;

    // Pixel memory with 1-cycle latency; garbage when not strobed exposes stale captures.
    always @(posedge clk) begin
        if (pix_rd_en) pix_data <= mem[pix_addr];
        else           pix_data <= 24'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Every read strobe must match the next address the bench expects.
    always @(negedge clk) begin
        if (pix_rd_en === 1'b1) begin
            check("rd_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) check("rd_addr", 32'(pix_addr), 32'(exp_addr.pop_front()));
        end
    end

    task automatic push_frame();
        for (int l = 0; l < int'(N_LEDS); l++) begin
            exp_addr.push_back(l);
            for (int b = 23; b >= 0; b--) exp_bits.push_back(mem[l][b]);
        end
    endtask

    task automatic run_frame(input int gap, input bit do_start, input int inj_at, input int abort_at);
        int lat;
        if (do_start) begin
            push_frame();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        lat = 1;
        while (all_bits_shifted && lat < 10) begin
            tick();
            lat++;
        end
        check("first_bit_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 72; i++) begin
            if (i == abort_at) begin
                new_bit_rqst = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_abs", 32'(all_bits_shifted), 32'd1);
                check("rst_bit", 32'(bit_to_transmit), 32'd0);
                check("rst_busy", 32'(frame_busy), 32'd0);
                check("rst_done", 32'(frame_done), 32'd0);
                exp_bits.delete();
                check("rst_rd_drain", 32'(exp_addr.size()), 32'd0);
                return;
            end
            if (i == 71) check("abs_before_last", 32'(all_bits_shifted), 32'd0);
            check($sformatf("bit%0d", i), 32'(bit_to_transmit), 32'(exp_bits.pop_front()));
            new_bit_rqst = 1'b1;
            frame_start  = (i == inj_at);
            tick();
            frame_start  = 1'b0;
            if (gap > 1) begin
                new_bit_rqst = 1'b0;
                repeat (gap - 1) tick();
            end
        end
        new_bit_rqst = 1'b0;
        check("abs_after_last", 32'(all_bits_shifted), 32'd1);
        check("bit_after_last", 32'(bit_to_transmit), 32'd0);
        check("rd_drain", 32'(exp_addr.size()), 32'd0);
    endtask

    // pend_mode: 0 none, 1 frame_start early in LATCH, 2 frame_start on the exit cycle.
    task automatic finish_latch(input int drop_at, input int pend_mode);
        int k;
        bit seen;
        new_frame_rqst = 1'b1;
        if (drop_at > 0) begin
            repeat (drop_at) tick();
            check("done_early", 32'(frame_done), 32'd0);
            new_frame_rqst = 1'b0;
            tick();
            new_frame_rqst = 1'b1;
        end
        k = 0;
        if (pend_mode == 1) begin
            push_frame();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            k = 1;
        end
        seen = 1'b0;
        while (!seen && k < 100) begin
            tick();
            k++;
            seen = frame_done;
        end
        // frame_done lands in the LATCH_CYCLES-th cycle with new_frame_rqst held high.
        check("done_lat", 32'(k), 32'(LATCH_CYCLES - 1));
        if (pend_mode == 2) begin
            push_frame();
            frame_start = 1'b1;
        end
        new_frame_rqst = 1'b0;
        tick();
        frame_start = 1'b0;
        check("done_pulse", 32'(frame_done), 32'd0);
        if (pend_mode != 0) begin
            check("pend_rd", 32'(pix_rd_en), 32'd1);
            check("pend_addr", 32'(pix_addr), 32'd0);
            check("pend_busy", 32'(frame_busy), 32'd1);
        end else begin
            check("idle_busy", 32'(frame_busy), 32'd0);
            check("idle_rd", 32'(pix_rd_en), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clk            = 1'b0;
        rst            = 1'b1;
        frame_start    = 1'b0;
        new_bit_rqst   = 1'b0;
        new_frame_rqst = 1'b0;
        n_vec          = 0;
        n_err          = 0;
        mem[0] = 24'hFF0000;
        mem[1] = 24'h00AA00;
        mem[2] = 24'h000001;
        mem[3] = 24'h5A5A5A;

        repeat (3) tick();
        check("rst_abs0", 32'(all_bits_shifted), 32'd1);
        check("rst_bit0", 32'(bit_to_transmit), 32'd0);
        check("rst_rd0", 32'(pix_rd_en), 32'd0);
        check("rst_addr0", 32'(pix_addr), 32'd0);
        check("rst_busy0", 32'(frame_busy), 32'd0);
        check("rst_done0", 32'(frame_done), 32'd0);
        rst = 1'b0;
        tick();

        // Bit requests while idle must change nothing.
        new_bit_rqst = 1'b1;
        repeat (4) tick();
        new_bit_rqst = 1'b0;
        check("idle_rqst_abs", 32'(all_bits_shifted), 32'd1);
        check("idle_rqst_bit", 32'(bit_to_transmit), 32'd0);
        check("idle_rqst_busy", 32'(frame_busy), 32'd0);

        run_frame(4, 1'b1, 40, -1);
        finish_latch(0, 0);

        run_frame(1, 1'b1, -1, -1);
        finish_latch(10, 1);

        run_frame(1, 1'b0, -1, -1);
        finish_latch(0, 2);

        run_frame(2, 1'b0, -1, 30);
        tick();

        run_frame(1, 1'b1, -1, -1);
        finish_latch(0, 0);
        repeat (3) tick();
        check("final_rd_drain", 32'(exp_addr.size()), 32'd0);
        check("final_bits_drain", 32'(exp_bits.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
